// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared constants and types for the 7-segment scan/decoder path.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int          NUM_DIGITS = 8;
    localparam int          IDX_W      = $clog2(NUM_DIGITS);
    localparam logic [3:0]  BLANK_CODE = 4'hF;

    typedef logic [4*NUM_DIGITS-1:0] disp_value_t;

    // Nibble for slot idx, or BLANK_CODE when it is a suppressed leading zero.
    function automatic logic [3:0] slot_digit(input disp_value_t value,
                                              input logic [IDX_W-1:0] idx,
                                              input logic lz_en);
        logic       upper_nonzero;
        logic [3:0] nib;
        upper_nonzero = 1'b0;
        nib           = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx) && value[4*i +: 4] != 4'h0)
                upper_nonzero = 1'b1;
            if (i == int'(idx))
                nib = value[4*i +: 4];
        end
        if (lz_en && idx != '0 && !upper_nonzero)
            return BLANK_CODE;
        return nib;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
// Module      : tick_divider
// Description : Free-running prescaler; tick is high while count == DIV-1.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : 8-digit multiplexed display scanner with frame-aligned update
//               of the shown value and optional leading-zero suppression.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int CLK_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           value_in,
    input  logic                  load,
    input  logic                  lz_en,
    output logic [3:0]            digit,
    output logic [NUM_DIGITS-1:0] tub_sel,
    output logic                  frame_start,
    output logic                  pending
);

    logic                  w_tick;
    logic                  w_wrap;
    logic [IDX_W-1:0]      w_idx_nxt;
    disp_value_t           w_shadow_nxt;

    logic [IDX_W-1:0]      r_idx;
    disp_value_t           r_shadow;
    disp_value_t           r_pend;
    logic                  r_pending;
    logic                  r_frame_start;
    logic [NUM_DIGITS-1:0] r_tub_sel;
    logic [3:0]            r_digit;

    tick_divider #(
        .DIV (CLK_DIV)
    ) u_tick_divider (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign w_wrap    = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_idx_nxt = w_tick ? r_idx + IDX_W'(1) : r_idx;

    // Shadow only changes on the wrap edge, so a frame never mixes two values.
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (w_wrap) begin
            if (load)
                w_shadow_nxt = value_in;
            else if (r_pending)
                w_shadow_nxt = r_pend;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx         <= '0;
            r_shadow      <= '0;
            r_pend        <= '0;
            r_pending     <= 1'b0;
            r_frame_start <= 1'b0;
            r_tub_sel     <= NUM_DIGITS'(1);
            r_digit       <= 4'h0;
        end else begin
            r_idx         <= w_idx_nxt;
            r_shadow      <= w_shadow_nxt;
            r_frame_start <= w_wrap;
            r_tub_sel     <= NUM_DIGITS'(1) << w_idx_nxt;
            r_digit       <= slot_digit(w_shadow_nxt, w_idx_nxt, lz_en);
            if (load)
                r_pend <= value_in;
            if (w_wrap)
                r_pending <= 1'b0;
            else if (load)
                r_pending <= 1'b1;
        end
    end

    assign digit       = r_digit;
    assign tub_sel     = r_tub_sel;
    assign frame_start = r_frame_start;
    assign pending     = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_driver
// Description : Randomized self-checking bench against a time-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int c_DIV   = 4;
    localparam int c_FRAME = 8 * c_DIV;

    logic        clk;
    logic        rst;
    logic [31:0] value_in;
    logic        load;
    logic        lz_en;
    logic [3:0]  digit;
    logic [7:0]  tub_sel;
    logic        frame_start;
    logic        pending;

    int n_checks;
    int n_fail;

    // Model: k counts edges since the last reset edge.
    int          m_k;
    logic [31:0] m_shadow;
    logic [31:0] m_pend;
    logic        m_pflag;
    logic        m_fs;
    logic        m_rst;
    logic        m_lz;

    seg_scan_driver #(
        .CLK_DIV (c_DIV)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .value_in    (value_in),
        .load        (load),
        .lz_en       (lz_en),
        .digit       (digit),
        .tub_sel     (tub_sel),
        .frame_start (frame_start),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, expv);
        end
    endtask

    function automatic logic [3:0] exp_digit(input logic [31:0] sh, input int idx, input logic lz);
        logic [31:0] upper;
        upper = sh >> (4 * idx);
        if (lz && idx > 0 && upper == 32'h0)
            return 4'hF;
        return upper[3:0];
    endfunction

    task automatic model_step(input logic r, input logic ld, input logic [31:0] v, input logic lz);
        logic wrap;
        m_rst = r;
        m_lz  = lz;
        if (r) begin
            m_k = 0; m_shadow = '0; m_pend = '0; m_pflag = 1'b0; m_fs = 1'b0;
        end else begin
            m_k++;
            wrap = (m_k % c_FRAME) == 0;
            if (ld) m_pend = v;
            if (wrap) begin
                if (ld)           m_shadow = v;
                else if (m_pflag) m_shadow = m_pend;
                m_pflag = 1'b0;
            end else if (ld) begin
                m_pflag = 1'b1;
            end
            m_fs = wrap;
        end
    endtask

    task automatic step(input logic r, input logic ld, input logic [31:0] v, input logic lz);
        int idx;
        rst = r; load = ld; value_in = v; lz_en = lz;
        model_step(r, ld, v, lz);
        @(posedge clk);
        #1;
        idx = (m_k / c_DIV) % 8;
        check("tub_sel", 32'(tub_sel), 32'(8'h01 << idx));
        check("digit", 32'(digit), m_rst ? 32'h0 : 32'(exp_digit(m_shadow, idx, m_lz)));
        check("pending", 32'(pending), 32'(m_pflag));
        check("frame_start", 32'(frame_start), 32'(m_fs));
    endtask

    function automatic logic [31:0] rand_value();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0:       return r;
            1:       return 32'h0;
            2:       return r & 32'h0000_00FF;
            3:       return r & 32'h000F_FFFF;
            default: return {28'h0, r[3:0]};
        endcase
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_k = 0; m_shadow = '0; m_pend = '0; m_pflag = 1'b0; m_fs = 1'b0;
        m_rst = 1'b1; m_lz = 1'b0;
        rst = 1'b1; load = 1'b0; value_in = '0; lz_en = 1'b0;

        // Reset, then a full idle frame and a bit more.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 32'h0, 1'b0);

        // Load mid-frame, watch it appear at the next frame.
        while ((m_k / c_DIV) % 8 != 3) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h12345678, 1'b0);
        for (int i = 0; i < 2 * c_FRAME; i++) step(1'b0, 1'b0, 32'h0, 1'b0);

        // Small values with suppression on and off.
        step(1'b0, 1'b1, 32'h00000042, 1'b1);
        for (int i = 0; i < 2 * c_FRAME; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < c_FRAME; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h00000000, 1'b1);
        for (int i = 0; i < 2 * c_FRAME; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h0000000A, 1'b1);
        for (int i = 0; i < 2 * c_FRAME; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Load exactly on the wrap edge.
        while ((m_k + 1) % c_FRAME != 0) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h99999999, 1'b1);
        for (int i = 0; i < c_FRAME; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset at slot 5 with a value pending.
        while ((m_k / c_DIV) % 8 != 2) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h87654321, 1'b0);
        while ((m_k / c_DIV) % 8 != 5) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 2 * c_FRAME; i++) step(1'b0, 1'b0, 32'h0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic r, ld, lz;
            r  = ($urandom_range(0, 299) == 0);
            ld = ($urandom_range(0, 29) == 0);
            lz = ($urandom_range(0, 49) == 0) ? ~lz_en : lz_en;
            step(r, ld, rand_value(), lz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
